// File: rtl/vc_arbiter_ctrl.sv
// VC0/VC1 read scheduler: FIFO bring-up, threshold latch,
// strict-priority reads and MSB routing to destination FIFOs.
module vc_arbiter_ctrl #(
  parameter int DATA_WIDTH   = 6,
  parameter int UMBRAL_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_vc0_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_vc1_in,
  input  logic                    empty_vc0,
  input  logic                    empty_vc1,
  input  logic [DATA_WIDTH-1:0]   data_vc0,
  input  logic [DATA_WIDTH-1:0]   data_vc1,
  input  logic                    pause_d0,
  input  logic                    pause_d1,
  output logic                    fifo_init,
  output logic [UMBRAL_WIDTH-1:0] umbral_vc0,
  output logic [UMBRAL_WIDTH-1:0] umbral_vc1,
  output logic                    rd_vc0,
  output logic                    rd_vc1,
  output logic                    wr_d0,
  output logic                    wr_d1,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [2:0]              state,
  output logic                    idle
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3
  } state_t;

  state_t state_q, state_d;

  logic [UMBRAL_WIDTH-1:0] umbral_vc0_q, umbral_vc0_d;
  logic [UMBRAL_WIDTH-1:0] umbral_vc1_q, umbral_vc1_d;
  logic                    rd_vc0_q, rd_vc0_d;
  logic                    rd_vc1_q, rd_vc1_d;
  logic                    pend_q, pend_d;
  logic                    src_q, src_d;
  logic                    wr_d0_q, wr_d0_d;
  logic                    wr_d1_q, wr_d1_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

  logic [DATA_WIDTH-1:0]   word;
  logic                    gate;
  logic                    in_flight;
  logic                    flush;

  always_comb begin
    state_d      = state_q;
    umbral_vc0_d = umbral_vc0_q;
    umbral_vc1_d = umbral_vc1_q;
    rd_vc0_d     = 1'b0;
    rd_vc1_d     = 1'b0;
    flush        = 1'b0;
    word         = src_q ? data_vc1 : data_vc0;
    gate         = ~pause_d0 & ~pause_d1;
    in_flight    = rd_vc0_q | rd_vc1_q | pend_q;
    pend_d       = rd_vc0_q | rd_vc1_q;
    src_d        = rd_vc1_q;

    unique case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        umbral_vc0_d = umbral_vc0_in;
        umbral_vc1_d = umbral_vc1_in;
        if (!init) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (init) begin
          state_d = S_INIT;
          flush   = 1'b1;
        end else if (!empty_vc0 || !empty_vc1) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (init) begin
          state_d = S_INIT;
          flush   = 1'b1;
        end else begin
          // any pause stalls: the word's destination is unknown until read
          if (gate && !empty_vc0) begin
            rd_vc0_d = 1'b1;
          end else if (gate && !empty_vc1) begin
            rd_vc1_d = 1'b1;
          end
          if (empty_vc0 && empty_vc1 && !in_flight)
            state_d = S_IDLE;
        end
      end
      default: state_d = S_RESET;
    endcase

    if (flush) pend_d = 1'b0;
    wr_d0_d    = pend_q & ~flush & ~word[DATA_WIDTH-1];
    wr_d1_d    = pend_q & ~flush &  word[DATA_WIDTH-1];
    data_out_d = (pend_q && !flush) ? word : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RESET;
      umbral_vc0_q <= '0;
      umbral_vc1_q <= '0;
      rd_vc0_q     <= 1'b0;
      rd_vc1_q     <= 1'b0;
      pend_q       <= 1'b0;
      src_q        <= 1'b0;
      wr_d0_q      <= 1'b0;
      wr_d1_q      <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      umbral_vc0_q <= umbral_vc0_d;
      umbral_vc1_q <= umbral_vc1_d;
      rd_vc0_q     <= rd_vc0_d;
      rd_vc1_q     <= rd_vc1_d;
      pend_q       <= pend_d;
      src_q        <= src_d;
      wr_d0_q      <= wr_d0_d;
      wr_d1_q      <= wr_d1_d;
      data_out_q   <= data_out_d;
    end
  end

  assign fifo_init  = (state_q == S_IDLE) | (state_q == S_ACTIVE);
  assign idle       = (state_q == S_IDLE);
  assign state      = state_q;
  assign umbral_vc0 = umbral_vc0_q;
  assign umbral_vc1 = umbral_vc1_q;
  assign rd_vc0     = rd_vc0_q;
  assign rd_vc1     = rd_vc1_q;
  assign wr_d0      = wr_d0_q;
  assign wr_d1      = wr_d1_q;
  assign data_out   = data_out_q;

endmodule
